serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes DIGIT operand bits per clock, least-significant digit first. The carry is kept in a flip-flop between steps.
It is the sequential successor of the single-bit full adder cell. It reuses that cell in a DIGIT-wide ripple slice, and adds width generalisation, subtract mode, signed-overflow detection and a start/done handshake.
It sits as an arithmetic leaf under small datapath controllers that can trade latency for area.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥1.
DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
STEPS (derived, localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only when ready (IDLE or DONE state)
sub  input  1  0: a+b+cin; 1: a+~b+1 (cin ignored)
a  input  WIDTH  operand A, latched on accepted start
b  input  WIDTH  operand B, latched on accepted start
cin  input  1  carry-in, latched on accepted start
busy  output  1  high while in RUN
done  output  1  single-cycle pulse, result valid
sum  output  WIDTH  result; holds last completed value
cout  output  1  carry out of MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy, done, sum, cout and overflow are all 0. Internal shift registers, step counter and carry flop are cleared. Reset mid-RUN aborts the operation with no done pulse.
- States are IDLE, RUN and DONE. ready = (state==IDLE || state==DONE).
- IDLE: when start=1, on the next edge latch a, b^{WIDTH{sub}} and carry = sub ? 1 : cin. Set count=0 and go to RUN.
- RUN: on each edge, add the low DIGIT bits of the A/B shift registers plus the carry flop in the digit slice.
  - Shift both operand registers right by DIGIT.
  - Shift the slice sum into the result register from the MSB side.
  - Update the carry flop and increment count.
- Last RUN step (count==STEPS-1):
  - Record the slice's carry-into-MSB for overflow.
  - Transfer the result register to sum, the final carry to cout, and the computed value to overflow.
  - Go to DONE.
- DONE: done=1 for exactly this one cycle and busy=0. If start=1, accept as in IDLE and go to RUN (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: start sampled at edge E0. done is high from edge E0+STEPS until edge E0+STEPS+1. Throughput is one operation per STEPS+1 cycles.
- sum, cout and overflow change only on the last RUN edge. They are stable during the following operation's RUN cycles.
- start while busy=1 is ignored; operands are not relatched.
- Inputs a, b, sub and cin may change freely after acceptance.
- DIGIT==WIDTH: STEPS=1, so done is asserted the edge after acceptance.
- WIDTH=1: overflow = cin_eff XOR cout (carry into MSB is the carry-in).

Decomposition:
- serial_adder_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - a clog2 helper function for the counter width, ($clog2(STEPS) bits, minimum 1).
- One sub-module, digit_adder #(DIGIT). It is a combinational ripple chain of DIGIT full_adder cells.
  - Inputs: x[DIGIT], y[DIGIT], ci.
  - Outputs: s[DIGIT], co, c_msb (carry into the top bit of the slice).
- serial_adder holds the FSM, counter, shift registers and output registers.

Test Plan:
- WIDTH=8, DIGIT=1: a=8'h3C, b=8'h5A, cin=0, sub=0 -> done exactly 8 cycles after the start edge; sum=8'h96, cout=0, overflow=1; busy high for 8 cycles.
- a=8'hFF, b=8'h01, cin=1, sub=0 -> sum=8'h01, cout=1, overflow=0. Then a=8'h10, b=8'h20, sub=1, cin=1 -> sum=8'hF0, cout=0, overflow=0 (cin ignored).
- sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, overflow=1.
  - Also pulse start at RUN cycle 3 with a=8'h00: it is ignored, and the result is unchanged.
- Back-to-back: hold start=1 through the DONE cycle with a=8'h01, b=8'h01.
  - The second operation starts with no idle cycle; its done comes 9 cycles after the first done, giving sum=8'h02.
  - The first result stays on sum throughout the second operation's RUN.
- Drop rst_n asynchronously (mid-cycle) at RUN cycle 4 -> busy, done, sum, cout and overflow go to 0 immediately. No done pulse follows, and the next start runs a clean 8-cycle operation.
- Repeat vectors 1–3 with DIGIT=4 (latency 2) and DIGIT=8 (latency 1) -> identical sum/cout/overflow.
  - Also run a 1000-vector random sweep checked against a+b+cin / a-b.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Step counter width; a single-step operation still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-wide ripple slice of full adder cells; c_msb exposes the carry into the top bit.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a_i (x[i]),
      .b_i (y[i]),
      .ci_i(c[i]),
      .s_o (s[i]),
      .co_o(c[i+1])
    );
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSD first, with start/done handshake
// and signed-overflow flag.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_w(STEPS);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_chk
    $error("serial_adder: DIGIT must be >=1 and divide WIDTH exactly");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT-1:0] dsum;
  logic             dco, dcm;
  logic             ready, last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_q[DIGIT-1:0]),
    .y    (b_q[DIGIT-1:0]),
    .ci   (carry_q),
    .s    (dsum),
    .co   (dco),
    .c_msb(dcm)
  );

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign last  = (cnt_q == CW'(STEPS - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters from the top so the LSD lands at bit 0 after STEPS shifts.
        r_d     = (r_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
        carry_d = dco;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          sum_d   = r_d;
          cout_d  = dco;
          ovf_d   = dcm ^ dco;
          state_d = ST_DONE;
        end
      end
      default: begin
        if (ready && start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at DIGIT=1, 4 and 8 (WIDTH=8), checked against integer arithmetic.
module tb_serial_adder;

  localparam int W = 8;
  localparam int N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]        start_s, sub_s, cin_s;
  logic [N-1:0][W-1:0] a_s, b_s;
  logic [N-1:0]        busy_s, done_s, cout_s, ovf_s;
  logic [N-1:0][W-1:0] sum_s;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    serial_adder #(.WIDTH(W), .DIGIT(g == 0 ? 1 : (g == 1 ? 4 : 8))) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_s[g]),
      .sub     (sub_s[g]),
      .a       (a_s[g]),
      .b       (b_s[g]),
      .cin     (cin_s[g]),
      .busy    (busy_s[g]),
      .done    (done_s[g]),
      .sum     (sum_s[g]),
      .cout    (cout_s[g]),
      .overflow(ovf_s[g])
    );
  end

  typedef struct {
    int         k;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         acc;
    bit         b2b;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         fails  = 0;
  int         last_done[N];
  int         bcnt[N];
  logic [7:0] last_sum[N];

  function automatic int steps_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 2 : 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer add/subtract, overflow from the signed range.
  function automatic exp_t model(input int k, input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic s);
    exp_t e;
    int   ua, ub, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r      = ua - ub;
      sr     = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      r      = ua + ub + int'(c);
      sr     = sa + sb + int'(c);
      e.cout = (r > 255);
    end
    e.k   = k;
    e.sum = r[7:0];
    e.ovf = (sr > 127) || (sr < -128);
    e.acc = 0;
    e.b2b = 1'b0;
    return e;
  endfunction

  // Monitor: compares results on done, and holds sum steady during RUN.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < N; k++) begin
        if (busy_s[k]) begin
          bcnt[k]++;
          chk($sformatf("sum_hold[%0d]", k), 32'(sum_s[k]), 32'(last_sum[k]));
        end
        if (done_s[k]) begin
          if (q.size() == 0) begin
            chk($sformatf("unexpected_done[%0d]", k), 32'(1), 32'(0));
          end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("inst[%0d]", k), 32'(k), 32'(e.k));
            chk($sformatf("sum[%0d]", k), 32'(sum_s[k]), 32'(e.sum));
            chk($sformatf("cout[%0d]", k), 32'(cout_s[k]), 32'(e.cout));
            chk($sformatf("ovf[%0d]", k), 32'(ovf_s[k]), 32'(e.ovf));
            chk($sformatf("latency[%0d]", k), 32'(cyc - e.acc), 32'(steps_of(k)));
            chk($sformatf("busy_cycles[%0d]", k), 32'(bcnt[k]), 32'(steps_of(k)));
            if (e.b2b)
              chk($sformatf("b2b_spacing[%0d]", k), 32'(cyc - last_done[k]),
                  32'(steps_of(k) + 1));
            last_sum[k] = e.sum;
          end
          last_done[k] = cyc;
          bcnt[k]      = 0;
        end
      end
    end
  end

  task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic s, input bit push, input bit b2b);
    int   n;
    exp_t e;
    n = 0;
    forever begin
      @(negedge clk);
      start_s[k] = 1'b0;
      if (!busy_s[k]) break;
      n++;
      if (n > 200) begin
        chk($sformatf("ready_timeout[%0d]", k), 32'(1), 32'(0));
        return;
      end
    end
    a_s[k]     = a;
    b_s[k]     = b;
    cin_s[k]   = c;
    sub_s[k]   = s;
    start_s[k] = 1'b1;
    if (push) begin
      e     = model(k, a, b, c, s);
      e.acc = cyc + 1;
      e.b2b = b2b;
      q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start_s = '0;
    end
  endtask

  initial begin
    int dn;
    start_s = '0;
    sub_s   = '0;
    cin_s   = '0;
    a_s     = '0;
    b_s     = '0;
    for (int k = 0; k < N; k++) begin
      last_done[k] = 0;
      bcnt[k]      = 0;
      last_sum[k]  = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_busy[%0d]", k), 32'(busy_s[k]), 32'(0));
      chk($sformatf("rst_done[%0d]", k), 32'(done_s[k]), 32'(0));
      chk($sformatf("rst_sum[%0d]", k), 32'(sum_s[k]), 32'(0));
      chk($sformatf("rst_cout[%0d]", k), 32'(cout_s[k]), 32'(0));
      chk($sformatf("rst_ovf[%0d]", k), 32'(ovf_s[k]), 32'(0));
    end
    rst_n = 1'b1;
    idle(2);

    // Directed vectors on every digit width, then back-to-back.
    for (int k = 0; k < N; k++) begin
      issue(k, 8'h3C, 8'h5A, 1'b0, 1'b0, 1, 0);
      idle(2);
      issue(k, 8'hFF, 8'h01, 1'b1, 1'b0, 1, 0);
      issue(k, 8'h10, 8'h20, 1'b1, 1'b1, 1, 0);
      idle(1);
      issue(k, 8'h80, 8'h01, 1'b0, 1'b1, 1, 0);
      if (k == 0) begin
        // Stray start during RUN must not relatch operands.
        @(negedge clk); start_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); start_s[0] = 1'b1; a_s[0] = 8'h00;
        @(negedge clk); start_s[0] = 1'b0;
      end
      issue(k, 8'h33, 8'h44, 1'b0, 1'b0, 1, 0);
      issue(k, 8'h01, 8'h01, 1'b0, 1'b0, 1, 1);
      idle(12);
    end

    // Abort mid-RUN with an asynchronous reset.
    issue(0, 8'h55, 8'h22, 1'b0, 1'b0, 0, 0);
    idle(4);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_s[0]), 32'(0));
    chk("abort_done", 32'(done_s[0]), 32'(0));
    chk("abort_sum", 32'(sum_s[0]), 32'(0));
    chk("abort_cout", 32'(cout_s[0]), 32'(0));
    chk("abort_ovf", 32'(ovf_s[0]), 32'(0));
    for (int k = 0; k < N; k++) begin
      last_sum[k] = 8'h00;
      bcnt[k]     = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_s[0]) dn++;
    end
    chk("no_done_after_abort", 32'(dn), 32'(0));
    issue(0, 8'h3C, 8'h5A, 1'b0, 1'b0, 1, 0);
    idle(12);

    // Random sweep per digit width, with occasional idle gaps.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < 1000; i++) begin
        issue(k, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1, 0);
        if ($urandom_range(3) == 0) idle(1);
      end
      idle(12);
    end

    dn = 0;
    while (q.size() != 0 && dn < 100) begin
      @(negedge clk);
      dn++;
    end
    chk("queue_drained", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
